// File: rtl/stim_sweep_capture_pkg.sv
// Shared state encoding, mode constants and MISR update for the stimulus sweeper.
// Combinational helpers only; no latency or flow control of its own.
package sweep_pkg;

   typedef enum logic [1:0] {IDLE, APPLY, EMIT, DONE} state_t;

   localparam logic MODE_STREAM = 1'b0;
   localparam logic MODE_SIG    = 1'b1;

   // Carried in 32 bits so one function serves every signature width; only the low w bits matter.
   function automatic logic [31:0] misr_step(input logic [31:0] sig, input logic [31:0] data,
                                             input logic [31:0] poly, input int w);
      logic [31:0] mask;
      logic        msb;
      mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      msb  = ((sig >> (w - 1)) & 32'd1) != 32'd0;
      return ((sig << 1) ^ (msb ? poly : 32'd0) ^ data) & mask;
   endfunction

endpackage

// File: rtl/stim_sweep_capture_misr.sv
// Multiple-input signature register: reloads SEED on load, folds data in on en.
// One cycle per update; no backpressure, the sweeper decides when en fires.
module sweep_misr
   import sweep_pkg::*;
#(
   parameter int               SIG_W = 16,
   parameter logic [SIG_W-1:0] POLY  = 16'h1021,
   parameter logic [SIG_W-1:0] SEED  = '0
) (
   input  logic             CK,
   input  logic             reset,
   input  logic             load,
   input  logic             en,
   input  logic [SIG_W-1:0] data,
   output logic [SIG_W-1:0] sig
);

   logic [SIG_W-1:0] sig_nxt;

   assign sig_nxt = SIG_W'(misr_step(32'(sig), 32'(data), 32'(POLY), SIG_W));

   always_ff @(posedge CK) begin
      if (!reset) begin
         sig <= SEED;
      end else if (load) begin
         sig <= SEED;
      end else if (en) begin
         sig <= sig_nxt;
      end
   end

endmodule

// File: rtl/stim_sweep_capture.sv
// Exhaustive stimulus sweeper: applies every IN_W-bit vector, samples the response after SETTLE cycles.
// Stream mode holds each record until rec_valid&&rec_ready; signature mode runs at SETTLE cycles/vector.
module stim_sweep_capture
   import sweep_pkg::*;
#(
   parameter int               IN_W   = 3,
   parameter int               OUT_W  = 1,
   parameter int               SETTLE = 1,
   parameter int               SIG_W  = 16,
   parameter logic [SIG_W-1:0] POLY   = 16'h1021,
   parameter logic [SIG_W-1:0] SEED   = '0
) (
   input  logic             CK,
   input  logic             reset,
   input  logic             start,
   input  logic             mode,
   output logic [IN_W-1:0]  dut_in,
   input  logic [OUT_W-1:0] dut_out,
   output logic             rec_valid,
   input  logic             rec_ready,
   output logic [IN_W-1:0]  rec_vec,
   output logic [OUT_W-1:0] rec_resp,
   output logic [SIG_W-1:0] signature,
   output logic             busy,
   output logic             done
);

   localparam int              CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
   localparam logic [IN_W:0]    VEC_LAST = {1'b0, {IN_W{1'b1}}};
   localparam logic [IN_W:0]    VEC_ONE  = 1;

   state_t           state;
   logic [IN_W:0]    vec;
   logic [IN_W:0]    vec_inc;
   logic [CNT_W-1:0] cnt;
   logic             mode_q;
   logic             sample;
   logic             misr_load;
   logic             misr_en;
   logic [SIG_W-1:0] misr_data;

   assign vec_inc   = vec + VEC_ONE;
   assign sample    = (state == APPLY) && (cnt == CNT_LAST);
   assign misr_load = (state == IDLE) && start;
   assign misr_en   = sample && (mode_q == MODE_SIG);
   assign misr_data = SIG_W'({vec[IN_W-1:0], dut_out});

   always_ff @(posedge CK) begin
      if (!reset) begin
         state     <= IDLE;
         vec       <= '0;
         cnt       <= '0;
         mode_q    <= MODE_STREAM;
         dut_in    <= '0;
         rec_valid <= 1'b0;
         rec_vec   <= '0;
         rec_resp  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  state  <= APPLY;
                  vec    <= '0;
                  cnt    <= '0;
                  mode_q <= mode;
                  busy   <= 1'b1;
                  dut_in <= '0;
               end
            end
            APPLY: begin
               if (cnt != CNT_LAST) begin
                  cnt <= cnt + CNT_W'(1);
               end else begin
                  cnt      <= '0;
                  rec_vec  <= vec[IN_W-1:0];
                  rec_resp <= dut_out;
                  if (mode_q == MODE_STREAM) begin
                     state     <= EMIT;
                     rec_valid <= 1'b1;
                  end else if (vec == VEC_LAST) begin
                     state  <= DONE;
                     done   <= 1'b1;
                     busy   <= 1'b0;
                     dut_in <= '0;
                  end else begin
                     vec    <= vec_inc;
                     dut_in <= vec_inc[IN_W-1:0];
                  end
               end
            end
            EMIT: begin
               // Record, vector and stimulus stay frozen until the consumer takes the record.
               if (rec_ready) begin
                  rec_valid <= 1'b0;
                  if (vec == VEC_LAST) begin
                     state  <= DONE;
                     done   <= 1'b1;
                     busy   <= 1'b0;
                     dut_in <= '0;
                  end else begin
                     state  <= APPLY;
                     vec    <= vec_inc;
                     dut_in <= vec_inc[IN_W-1:0];
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
         endcase
      end
   end

   sweep_misr #(
      .SIG_W (SIG_W),
      .POLY  (POLY),
      .SEED  (SEED)
   ) u_misr (
      .CK    (CK),
      .reset (reset),
      .load  (misr_load),
      .en    (misr_en),
      .data  (misr_data),
      .sig   (signature)
   );

endmodule

// File: tb/tb_stim_sweep_capture.sv
// Bench for stim_sweep_capture: a 3-bit/SETTLE=1 instance and a 4-bit/SETTLE=3 instance
// whose modelled DUT only produces the right answer once its input has been stable long enough.
module tb_stim_sweep_capture;
   import sweep_pkg::*;

   localparam int SETTLE_B = 3;

   typedef struct {
      logic [2:0] vec;
      logic       resp;
   } rec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset, start, mode, ready;
   logic sel;
   logic a_start, b_start;
   assign a_start = start & ~sel;
   assign b_start = start & sel;

   logic [2:0]  a_dut_in;
   logic        a_dut_out, a_valid, a_resp, a_busy, a_done;
   logic [2:0]  a_vec;
   logic [3:0]  a_sig;
   logic [3:0]  b_dut_in, b_vec;
   logic [1:0]  b_dut_out, b_resp;
   logic        b_valid, b_busy, b_done;
   logic [15:0] b_sig;

   logic       tt_a [8];
   logic [1:0] tt_b [16];
   int         b_age = 0;
   logic [3:0] b_last = '0;

   assign a_dut_out = tt_a[a_dut_in];
   assign b_dut_out = (b_age >= SETTLE_B - 1) ? tt_b[b_dut_in] : ~tt_b[b_dut_in];

   // Slow benchmark model: counts edges since its input last changed.
   always @(posedge clk) begin
      if (b_dut_in != b_last) begin
         b_last <= b_dut_in;
         b_age  <= 1;
      end else if (b_age < 100) begin
         b_age <= b_age + 1;
      end
   end

   stim_sweep_capture #(.IN_W(3), .OUT_W(1), .SETTLE(1), .SIG_W(4), .POLY(4'h3), .SEED(4'h0)) u_a (
      .CK(clk), .reset(reset), .start(a_start), .mode(mode), .dut_in(a_dut_in), .dut_out(a_dut_out),
      .rec_valid(a_valid), .rec_ready(ready), .rec_vec(a_vec), .rec_resp(a_resp),
      .signature(a_sig), .busy(a_busy), .done(a_done));

   stim_sweep_capture #(.IN_W(4), .OUT_W(2), .SETTLE(SETTLE_B), .SIG_W(16), .POLY(16'h1021),
                        .SEED(16'hACE1)) u_b (
      .CK(clk), .reset(reset), .start(b_start), .mode(mode), .dut_in(b_dut_in), .dut_out(b_dut_out),
      .rec_valid(b_valid), .rec_ready(ready), .rec_vec(b_vec), .rec_resp(b_resp),
      .signature(b_sig), .busy(b_busy), .done(b_done));

   logic [31:0] cur_dut_in, cur_vec, cur_resp, cur_sig;
   logic        cur_valid, cur_busy, cur_done;
   always_comb begin
      cur_dut_in = sel ? 32'(b_dut_in) : 32'(a_dut_in);
      cur_vec    = sel ? 32'(b_vec)    : 32'(a_vec);
      cur_resp   = sel ? 32'(b_resp)   : 32'(a_resp);
      cur_sig    = sel ? 32'(b_sig)    : 32'(a_sig);
      cur_valid  = sel ? b_valid : a_valid;
      cur_busy   = sel ? b_busy  : a_busy;
      cur_done   = sel ? b_done  : a_done;
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int model_resp(input logic s, input int v);
      return s ? int'(tt_b[v]) : int'(tt_a[v]);
   endfunction

   // Signature as polynomial arithmetic: double, reduce modulo the top bit, add the record.
   function automatic logic [31:0] ref_sig(input logic s);
      longint w   = s ? 16 : 4;
      longint top = longint'(1) << w;
      longint p   = s ? 'h1021 : 'h3;
      longint r   = s ? 'hACE1 : 0;
      int     n   = s ? 16 : 8;
      int     ow  = s ? 2 : 1;
      for (int v = 0; v < n; v++) begin
         r = r * 2;
         if (r >= top) r = (r - top) ^ p;
         r = r ^ (longint'(v) * (longint'(1) << ow) + longint'(model_resp(s, v)));
      end
      return 32'(r);
   endfunction

   int got_vec[$];
   int got_resp[$];
   int valid_cycles, stall_ok, hold_bad, dones, done_at, tail_busy;

   task automatic sweep(input logic s, input logic m, input int rdy_pct, input int stall_vec,
                        input logic spam, input int exp_done, input string tag);
      int          settle = s ? SETTLE_B : 1;
      int          n      = s ? 16 : 8;
      int          hold   = 0;
      int          stall_left = 5;
      logic        pv = 1'b0, pr = 1'b0;
      logic [31:0] pvec = '0, pdin = '0;
      got_vec.delete();
      got_resp.delete();
      valid_cycles = 0; stall_ok = 0; hold_bad = 0; dones = 0; done_at = -1; tail_busy = 0;
      sel = s; mode = m; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_busy_at_start"}, 32'(cur_busy), 1);
      check({tag, "_dut_in_at_start"}, cur_dut_in, 0);
      for (int c = 0; c < 400; c++) begin
         if (cur_done) begin
            dones++;
            if (done_at < 0) done_at = c;
         end
         if (cur_valid) begin
            valid_cycles++;
            if (!pv && hold != settle) hold_bad++;
            hold = 0;
         end else if (cur_busy) begin
            hold++;
         end
         if (pv && !pr && (!cur_valid || cur_vec != pvec || cur_dut_in != pdin)) hold_bad++;
         ready = ($urandom_range(99) < rdy_pct);
         if (cur_valid && cur_vec == stall_vec && stall_left > 0) begin
            ready = 1'b0;
            stall_left--;
            if (cur_dut_in == stall_vec) stall_ok++;
         end
         if (cur_valid && ready) begin
            got_vec.push_back(int'(cur_vec));
            got_resp.push_back(int'(cur_resp));
         end
         pv = cur_valid; pr = ready; pvec = cur_vec; pdin = cur_dut_in;
         start = spam;
         mode  = spam ? 1'($urandom) : m;
         if (done_at >= 0) break;
         @(negedge clk);
      end
      for (int t = 0; t < 4; t++) begin
         @(negedge clk);
         start = 1'b0;
         if (cur_busy) tail_busy++;
         if (cur_done) dones++;
      end
      check({tag, "_finished"}, 32'(done_at >= 0), 1);
      if (exp_done >= 0) check({tag, "_done_cycle"}, done_at, exp_done);
      check({tag, "_done_pulses"}, dones, 1);
      check({tag, "_idle_after"}, tail_busy, 0);
      check({tag, "_hold_violations"}, hold_bad, 0);
      if (m == MODE_STREAM) begin
         check({tag, "_nrec"}, got_vec.size(), n);
         for (int v = 0; v < n && v < got_vec.size(); v++)
            check({tag, "_rec"}, got_vec[v] * 4 + got_resp[v], v * 4 + model_resp(s, v));
         check({tag, "_sig_is_seed"}, cur_sig, s ? 32'hACE1 : 32'h0);
      end else begin
         check({tag, "_no_records"}, valid_cycles, 0);
         check({tag, "_sig"}, cur_sig, ref_sig(s));
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rec_t t1[8];
      int   found;
      t1[0] = '{3'd0, 1'b0}; t1[1] = '{3'd1, 1'b1}; t1[2] = '{3'd2, 1'b1}; t1[3] = '{3'd3, 1'b0};
      t1[4] = '{3'd4, 1'b1}; t1[5] = '{3'd5, 1'b0}; t1[6] = '{3'd6, 1'b0}; t1[7] = '{3'd7, 1'b1};

      reset = 1'b0; start = 1'b0; mode = 1'b0; ready = 1'b0; sel = 1'b0;
      for (int i = 0; i < 8; i++) tt_a[i] = ^i[2:0];
      for (int i = 0; i < 16; i++) tt_b[i] = 2'($urandom);
      repeat (3) @(negedge clk);
      check("rst_dut_in", cur_dut_in, 0);
      check("rst_valid", 32'(cur_valid), 0);
      check("rst_vec", cur_vec, 0);
      check("rst_resp", cur_resp, 0);
      check("rst_sig_a", cur_sig, 0);
      check("rst_busy", 32'(cur_busy), 0);
      check("rst_done", 32'(cur_done), 0);
      check("rst_sig_b", 32'(b_sig), 32'hACE1);
      reset = 1'b1;
      @(negedge clk);

      // Parity benchmark, consumer always ready.
      sweep(1'b0, MODE_STREAM, 100, -1, 1'b0, 16, "t1");
      for (int i = 0; i < 8 && i < got_vec.size(); i++)
         check("t1_table", got_vec[i] * 2 + got_resp[i], int'(t1[i].vec) * 2 + int'(t1[i].resp));

      // Consumer stalls five cycles on vector 3.
      sweep(1'b0, MODE_STREAM, 100, 3, 1'b0, 21, "t2");
      check("t2_stall_stable", stall_ok, 5);
      for (int i = 0; i < 8 && i < got_vec.size(); i++)
         check("t2_table", got_vec[i] * 2 + got_resp[i], int'(t1[i].vec) * 2 + int'(t1[i].resp));

      // Signature of an all-zero response.
      for (int i = 0; i < 8; i++) tt_a[i] = 1'b0;
      sweep(1'b0, MODE_SIG, 100, -1, 1'b0, 8, "t3");
      check("t3_sig_const", 32'(a_sig), 32'hD);

      // Slow benchmark, three-cycle settle, streaming.
      sweep(1'b1, MODE_STREAM, 100, -1, 1'b0, 64, "t4");
      sweep(1'b1, MODE_STREAM, 50, -1, 1'b0, -1, "t4r");

      // Slow benchmark, signature; then reset from IDLE must restore the seed.
      sweep(1'b1, MODE_SIG, 100, -1, 1'b0, 48, "t5");
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check("t5_reset_sig", 32'(b_sig), 32'hACE1);

      // Reset while vector 5 is waiting in EMIT.
      for (int i = 0; i < 8; i++) tt_a[i] = ^i[2:0];
      sel = 1'b0; mode = MODE_STREAM; ready = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      found = 0;
      for (int c = 0; c < 100; c++) begin
         if (cur_valid && cur_vec == 5) begin
            found = 1;
            break;
         end
         @(negedge clk);
      end
      check("t6_reached_vec5", found, 1);
      ready = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      check("t6_dut_in", cur_dut_in, 0);
      check("t6_valid", 32'(cur_valid), 0);
      check("t6_vec", cur_vec, 0);
      check("t6_busy", 32'(cur_busy), 0);
      check("t6_done", 32'(cur_done), 0);
      check("t6_sig", cur_sig, 0);
      reset = 1'b1;
      sweep(1'b0, MODE_STREAM, 100, -1, 1'b0, 16, "t6");

      // start and mode toggled throughout the sweep and during DONE.
      for (int i = 0; i < 16; i++) tt_b[i] = 2'($urandom);
      sweep(1'b1, MODE_SIG, 100, -1, 1'b1, 48, "t7");
      sweep(1'b0, MODE_STREAM, 100, -1, 1'b1, 16, "t7s");

      // Random benchmarks and consumer behaviour.
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 8; i++) tt_a[i] = 1'($urandom);
         for (int i = 0; i < 16; i++) tt_b[i] = 2'($urandom);
         sweep(1'b0, 1'(r % 2), 70, -1, 1'b0, -1, "rnd_a");
         sweep(1'b1, 1'(r % 2), 60, -1, 1'b0, -1, "rnd_b");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/stim_sweep_capture.md
# stim_sweep_capture

Synthesizable exhaustive stimulus sweeper and response capturer for trojan-detection characterisation of small combinational/sequential benchmark cores. It drives every input vector 0 … 2^IN_W−1 into the device under test, waits a programmable settle time, samples the response, and either streams (vector, response) records over a valid/ready port or compacts them into a MISR signature. It sits between a benchmark instance and the capture/log path, replacing per-benchmark hand-written vector lists with one parametrised engine.

## Interface
- IN_W, 3, DUT input width; sweep length 2^IN_W vectors (1 ≤ IN_W ≤ 16)
- OUT_W, 1, DUT output width
- SETTLE, 1, cycles each vector is held before sampling (≥ 1)
- SIG_W, 16, signature width; IN_W+OUT_W ≤ SIG_W
- POLY, 16'h1021, MISR feedback taps (SIG_W bits)
- SEED, 0, signature value loaded at sweep start
- CK  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  begin sweep; sampled only in IDLE
- mode  in  1  0 = stream records, 1 = signature only; latched with start
- dut_in  out  IN_W  stimulus vector to DUT
- dut_out  in  OUT_W  DUT response
- rec_valid  out  1  record available (stream mode)
- rec_ready  in  1  consumer accepts record
- rec_vec  out  IN_W  vector of current record
- rec_resp  out  OUT_W  sampled response of current record
- signature  out  SIG_W  MISR result
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at sweep end

## Operation
- States: IDLE, APPLY, EMIT, DONE.
- IDLE: busy=0, dut_in=0, rec_valid=0. start=1 → APPLY, vec=0, settle counter=0, mode latched, signature←SEED.
- APPLY: dut_in=vec held; counter counts SETTLE cycles. On the edge ending the SETTLE-th cycle, dut_out registered into rec_resp, rec_vec←vec.
  - Stream mode → EMIT.
  - Signature mode: signature ← ({sig[SIG_W-2:0],0} ^ (sig[SIG_W-1] ? POLY : 0)) ^ zero-extend({vec,dut_out}); then vec+1 and stay in APPLY, or → DONE if vec was 2^IN_W−1.
- EMIT: rec_valid=1; rec_vec, rec_resp, dut_in stable until rec_valid&&rec_ready. On handshake: last vector → DONE, else vec+1 → APPLY. rec_valid never deasserts without handshake.
- DONE: done=1 for exactly one cycle, busy=0, dut_in=0; → IDLE. signature holds until next accepted start.
- Vector counter is IN_W+1 bits internally; no wrap into a second sweep.
- start while busy or in DONE: ignored. mode changes mid-sweep: ignored.
- reset low (any state, incl. mid-EMIT): next edge → IDLE; all outputs 0, signature=SEED; pending record discarded.

## Timing
- Reset values: dut_in=0, rec_valid=0, rec_vec=0, rec_resp=0, signature=SEED, busy=0, done=0.
- start accepted at edge k → busy=1 and dut_in=0 visible after edge k; first sample at edge k+SETTLE.
- Stream, rec_ready held high: SETTLE+1 cycles per vector; next vector visible after handshake edge.
- Signature mode: SETTLE cycles per vector; done visible after edge k+2^IN_W·SETTLE.
- No combinational path from rec_ready or dut_out to any output.

## Structure
- Package sweep_pkg: state enum (IDLE/APPLY/EMIT/DONE), MODE_STREAM/MODE_SIG constants, misr_step function (width-generic via parameters on caller).
- One sub-module: sweep_misr (SIG_W, POLY, SEED; load, en, data in; sig out). FSM and counters in top.

## Test plan
- IN_W=3, OUT_W=1, SETTLE=1, DUT dut_out=^dut_in, stream, ready=1 -> 8 records (000,0)(001,1)(010,1)(011,0)(100,1)(101,0)(110,0)(111,1), done 1 cycle after last handshake.
- Same, rec_ready low 5 cycles on vector 3 -> rec_valid stays high, rec_vec=011, dut_in=011 stable; sweep resumes on ready.
- IN_W=3, SIG_W=4, POLY=4'h3, SEED=0, dut_out tied 0, signature mode -> signature=4'hD, rec_valid never asserted, done after 8·SETTLE cycles.
- SETTLE=3 stream mode -> each dut_in value held ≥ 3 cycles before rec_valid; response sampled on 3rd edge.
- reset low during EMIT of vector 5 -> next cycle IDLE, all outputs 0; new start re-sweeps from vector 0.
- start pulsed while busy and during DONE -> ignored; exactly one done pulse per accepted start.
